// File: rtl/weight_bram_scheduler_pkg.sv
// Shared types and constants for the weight BRAM scheduler.
// Holds FSM encoding, default BRAM latency and weight region bases.
package weight_bram_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam int BRAM_RD_LAT = 2;

  // Weight region start addresses inside the shared BRAM
  localparam logic [17:0] L0_BASE     = 18'd0;
  localparam logic [17:0] L1_BASE     = 18'd8448;
  localparam logic [17:0] L1_B12_BASE = 18'd101376;
  localparam logic [17:0] L2_BASE     = 18'd110592;
  localparam logic [17:0] L3_BASE     = 18'd184320;

endpackage

// File: rtl/weight_bram_scheduler_arb.sv
// Combinational round-robin arbiter: first requester at or after
// the pointer, wrapping, as a one-hot grant plus its index.
module rr_arbiter_onehot #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [N_REQ-1:0]    o_grant,
  output logic [ID_WIDTH-1:0] o_idx
);

  logic                w_found;
  logic [ID_WIDTH-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_j = ID_WIDTH'((int'(i_ptr) + i) % N_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/weight_bram_scheduler.sv
// Time-shares one read-only weight BRAM between N_REQ burst loaders,
// returning read words as an id-tagged valid/last stream.
module weight_bram_scheduler
  import weight_bram_scheduler_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 19,
  parameter int RD_LAT     = BRAM_RD_LAT,
  parameter int ID_WIDTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            done,
  output logic                        busy,
  output logic [W-1:0]                rd_data,
  output logic                        rd_valid,
  output logic [ID_WIDTH-1:0]         rd_id,
  output logic                        rd_last,
  output logic                        bram_en,
  output logic                        bram_ren,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  input  logic [W-1:0]                bram_dout
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t              r_state;
  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] r_gid;
  logic [CW-1:0]       r_cnt;
  logic [RD_LAT-1:0]   r_vp;
  logic [RD_LAT-1:0]   r_lp;
  logic [ID_WIDTH-1:0] r_ip [RD_LAT];
  logic [W-1:0]        r_hold;

  logic [N_REQ-1:0]      w_oh;
  logic [ID_WIDTH-1:0]   w_idx;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [CW-1:0]         w_len;
  logic                  w_any;
  logic                  w_drained;

  rr_arbiter_onehot #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_oh),
    .o_idx   (w_idx)
  );

  assign w_any = |w_oh;

  always_comb begin
    w_base = '0;
    w_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == ID_WIDTH'(i)) begin
        w_base = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_len  = req_len[i*LEN_WIDTH +: CW];
      end
    end
  end

  // Done may fire while the final word is on the output stage
  always_comb begin
    w_drained = !bram_ren;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (r_vp[i]) w_drained = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gid     <= '0;
      r_cnt     <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      bram_en   <= 1'b0;
      bram_ren  <= 1'b0;
      bram_addr <= '0;
    end else begin
      done <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            grant <= w_oh;
            r_gid <= w_idx;
            r_cnt <= w_len;
            busy  <= 1'b1;
            if (w_len != '0) begin
              bram_en   <= 1'b1;
              bram_ren  <= 1'b1;
              bram_addr <= w_base;
              r_state   <= ISSUE;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        ISSUE: begin
          if (r_cnt == ONE) begin
            bram_ren <= 1'b0;
            r_state  <= DRAIN;
          end else begin
            bram_addr <= bram_addr + 1'b1;
            r_cnt     <= r_cnt - ONE;
          end
        end
        DRAIN: begin
          if (w_drained) begin
            done[r_gid] <= 1'b1;
            grant       <= '0;
            busy        <= 1'b0;
            bram_en     <= 1'b0;
            r_ptr       <= (r_gid == ID_WIDTH'(N_REQ - 1)) ?
                           '0 : r_gid + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vp   <= '0;
      r_lp   <= '0;
      r_hold <= '0;
      for (int i = 0; i < RD_LAT; i++) r_ip[i] <= '0;
    end else begin
      r_vp[0] <= bram_ren;
      r_lp[0] <= bram_ren && (r_cnt == ONE);
      r_ip[0] <= r_gid;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vp[i] <= r_vp[i-1];
        r_lp[i] <= r_lp[i-1];
        r_ip[i] <= r_ip[i-1];
      end
      if (rd_valid) r_hold <= bram_dout;
    end
  end

  assign rd_valid = r_vp[RD_LAT-1];
  assign rd_last  = r_lp[RD_LAT-1];
  assign rd_id    = r_ip[RD_LAT-1];
  assign rd_data  = rd_valid ? bram_dout : r_hold;

endmodule

// File: tb/tb_weight_bram_scheduler.sv
// Self-checking bench for weight_bram_scheduler: directed and random
// burst scenarios against a transaction-level schedule model.
module tb_weight_bram_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 18;
  localparam int LW = 19;
  localparam int RL = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_base;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    grant, done;
  logic            busy;
  logic [W-1:0]    rd_data;
  logic            rd_valid;
  logic [IW-1:0]   rd_id;
  logic            rd_last;
  logic            bram_en, bram_ren;
  logic [AW-1:0]   bram_addr;
  logic [W-1:0]    bram_dout;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] wdat(int a);
    return 8'((a * 29) ^ (a >> 5) ^ 90);
  endfunction

  logic [W-1:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    if (bram_en) s1 <= wdat(int'(bram_addr));
    s2 <= s1;
  end
  assign bram_dout = s2;

  weight_bram_scheduler #(
    .N_REQ(N), .W(W), .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW), .RD_LAT(RL), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_base(req_base), .req_len(req_len),
    .grant(grant), .done(done), .busy(busy),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_id(rd_id), .rd_last(rd_last),
    .bram_en(bram_en), .bram_ren(bram_ren),
    .bram_addr(bram_addr), .bram_dout(bram_dout)
  );

  typedef struct packed {int c; int a; int b; int d;} ev_t;

  ev_t g_gnt[$], e_gnt[$], g_bsy[$], e_bsy[$];
  ev_t g_adr[$], e_adr[$], g_rd[$], e_rd[$];
  ev_t g_dn[$], e_dn[$];

  int nvec = 0;
  int nerr = 0;
  int m_ptr = 0;
  int reps[N];
  int bases[N][4];
  int lens[N][4];

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(int c, int a, int b, int d);
    ev_t e;
    e.c = c; e.a = a; e.b = b; e.d = d;
    return e;
  endfunction

  task automatic cmpq(string tag, ev_t g[$], ev_t e[$]);
    chk({tag, "_count"}, 128'(g.size()), 128'(e.size()));
    for (int i = 0; i < e.size() && i < g.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), g[i], e[i]);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_grant"}, 128'(grant), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
    chk({tag, "_rd_id"}, 128'(rd_id), 128'(0));
    chk({tag, "_rd_last"}, 128'(rd_last), 128'(0));
    chk({tag, "_rd_data"}, 128'(rd_data), 128'(0));
    chk({tag, "_bram_en"}, 128'(bram_en), 128'(0));
    chk({tag, "_bram_ren"}, 128'(bram_ren), 128'(0));
    chk({tag, "_bram_addr"}, 128'(bram_addr), 128'(0));
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      reps[i] = 0;
      for (int r = 0; r < 4; r++) begin
        bases[i][r] = 0;
        lens[i][r]  = 0;
      end
    end
  endtask

  // Schedule of every burst: round robin over pending requesters
  task automatic model(int k, output int ld, output bit hw);
    int t, g, b, l, d, a;
    int rc[N];
    t  = k;
    ld = 0;
    hw = 1'b0;
    for (int i = 0; i < N; i++) rc[i] = 0;
    while (1) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        int jj;
        jj = (m_ptr + i) % N;
        if (g < 0 && rc[jj] < reps[jj]) g = jj;
      end
      if (g < 0) break;
      b = bases[g][rc[g]];
      l = lens[g][rc[g]];
      e_gnt.push_back(mk(t, 1 << g, 0, 0));
      e_bsy.push_back(mk(t, 1, 0, 0));
      for (int w = 0; w < l; w++) begin
        a = (b + w) % (1 << AW);
        e_adr.push_back(mk(t + w, a, 0, 0));
        e_rd.push_back(mk(t + RL + w, g, int'(wdat(a)),
                          (w == l - 1) ? 1 : 0));
        ld = int'(wdat(a));
        hw = 1'b1;
      end
      d = (l == 0) ? t + 1 : t + RL + l;
      e_dn.push_back(mk(d, g, 0, 0));
      e_gnt.push_back(mk(d, 0, 0, 0));
      e_bsy.push_back(mk(d, 0, 0, 0));
      rc[g]++;
      m_ptr = (g + 1) % N;
      t = d + 1;
    end
  endtask

  task automatic drive(int i, int r);
    req_base[i*AW +: AW] = AW'(bases[i][r]);
    req_len[i*LW +: LW]  = LW'(lens[i][r]);
  endtask

  task automatic run_scn(string tag);
    int left, guard, tail, ld;
    bit hw;
    int rc[N];
    logic [N-1:0] pg;
    logic pb;
    g_gnt.delete(); e_gnt.delete(); g_bsy.delete(); e_bsy.delete();
    g_adr.delete(); e_adr.delete(); g_rd.delete(); e_rd.delete();
    g_dn.delete(); e_dn.delete();
    left = 0;
    for (int i = 0; i < N; i++) begin
      rc[i] = 0;
      left += reps[i];
      req[i] = (reps[i] > 0);
      drive(i, 0);
    end
    model(cyc + 1, ld, hw);
    pg = grant;
    pb = busy;
    guard = 0;
    tail = 0;
    while (tail < 3 && guard < 3000) begin
      @(negedge clk);
      guard++;
      chk({tag, "_gnt_1hot"}, 128'($onehot0(grant)), 128'(1));
      chk({tag, "_done_1hot"}, 128'($onehot0(done)), 128'(1));
      chk({tag, "_ren_en"}, 128'(!bram_ren || bram_en), 128'(1));
      if (grant !== pg) g_gnt.push_back(mk(cyc, int'(grant), 0, 0));
      if (busy !== pb) g_bsy.push_back(mk(cyc, int'(busy), 0, 0));
      pg = grant;
      pb = busy;
      if (bram_ren)
        g_adr.push_back(mk(cyc, int'(bram_addr), 0, 0));
      if (rd_valid)
        g_rd.push_back(mk(cyc, int'(rd_id), int'(rd_data),
                          int'(rd_last)));
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          g_dn.push_back(mk(cyc, i, 0, 0));
          rc[i]++;
          left--;
          if (rc[i] >= reps[i]) req[i] = 1'b0;
          else drive(i, rc[i]);
        end
      end
      if (left <= 0) tail++;
    end
    chk({tag, "_in_time"}, 128'(guard < 3000), 128'(1));
    cmpq({tag, "_grant"}, g_gnt, e_gnt);
    cmpq({tag, "_busy"}, g_bsy, e_bsy);
    cmpq({tag, "_addr"}, g_adr, e_adr);
    cmpq({tag, "_rd"}, g_rd, e_rd);
    cmpq({tag, "_done"}, g_dn, e_dn);
    if (hw) chk({tag, "_rd_hold"}, 128'(rd_data), 128'(ld));
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_base = '0;
    req_len  = '0;
    clr();
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    m_ptr = 0;

    clr();
    reps[0] = 1; bases[0][0] = 101376; lens[0][0] = 4;
    run_scn("single");

    clr();
    for (int i = 0; i < N; i++) begin
      reps[i] = 1; bases[i][0] = 1000 * i + 7; lens[i][0] = 3;
    end
    run_scn("all4");

    clr();
    reps[0] = 1; bases[0][0] = 262142; lens[0][0] = 4;
    run_scn("wrap");

    clr();
    reps[2] = 1; bases[2][0] = 555; lens[2][0] = 0;
    run_scn("zero_len");

    // Pointer sits at 3 here, so only a reset pointer picks 1 over 3
    clr();
    req = '0;
    req[0] = 1'b1;
    req_base[0 +: AW] = AW'(5000);
    req_len[0 +: LW]  = LW'(8);
    @(negedge clk);
    chk("abort_grant", 128'(grant), 128'(4'b0001));
    req[1] = 1'b1;
    req[3] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mid_reset");
    req = '0;
    rst_n = 1'b1;
    m_ptr = 0;
    reps[1] = 1; bases[1][0] = 40000; lens[1][0] = 2;
    reps[3] = 1; bases[3][0] = 70000; lens[3][0] = 3;
    run_scn("post_reset");

    clr();
    reps[0] = 2; bases[0][0] = 10; lens[0][0] = 2;
    bases[0][1] = 20; lens[0][1] = 1;
    reps[3] = 1; bases[3][0] = 30; lens[3][0] = 2;
    run_scn("fair");

    for (int s = 0; s < 6; s++) begin
      clr();
      for (int i = 0; i < N; i++) begin
        reps[i] = $urandom_range(0, 2);
        for (int r = 0; r < 4; r++) begin
          if ($urandom_range(0, 3) == 0)
            bases[i][r] = (1 << AW) - 1 - $urandom_range(0, 3);
          else
            bases[i][r] = $urandom_range(0, (1 << AW) - 1);
          lens[i][r] = $urandom_range(0, 5);
        end
      end
      if (reps[0] + reps[1] + reps[2] + reps[3] == 0) reps[s % N] = 1;
      run_scn($sformatf("rand%0d", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/weight_bram_scheduler.md
Name: weight_bram_scheduler

Overview:
Time-shares one read-only weight BRAM between N_REQ per-layer weight loaders. Each loader requests a burst given as a base address and a word count. The block grants one requester at a time in round-robin order, sequences the BRAM enable, read-enable and address, and returns the read words as a valid-qualified stream tagged with the requester ID. It sits between the layer weight loaders and the single BRAM instance, replacing direct BRAM ownership by each loader.

Parameters:
N_REQ, 4, number of requesters
W, 8, weight word width (bits)
ADDR_WIDTH, 18, BRAM address width
LEN_WIDTH, 19, burst length field width (words)
RD_LAT, 2, BRAM read latency (cycles from address to dout)
ID_WIDTH, 2, requester ID width, equal to clog2(N_REQ)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  synchronous active-low reset
req  in  N_REQ  per-requester burst request; held high until that requester's done pulse
req_base  in  N_REQ*ADDR_WIDTH  packed start addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_len  in  N_REQ*LEN_WIDTH  packed burst lengths in words
grant  out  N_REQ  one-hot; high for the whole burst of the owning requester
done  out  N_REQ  one-cycle pulse per requester when its burst completes
busy  out  1  high in any non-IDLE state
rd_data  out  W  returned word
rd_valid  out  1  rd_data valid this cycle
rd_id  out  ID_WIDTH  owner of rd_data
rd_last  out  1  final word of the burst
bram_en  out  1  BRAM enable
bram_ren  out  1  BRAM read enable (BRAM wen is tied 0 outside this block)
bram_addr  out  ADDR_WIDTH  BRAM address
bram_dout  in  W  BRAM read data

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All outputs go to 0.
  - State goes to IDLE, the RR pointer to 0, and the valid/last/id pipeline is flushed.
  - Reset during a burst aborts it: no done pulse and no further rd_valid.
- States:
  - IDLE:
    - On an edge with any req high, select the first requester with req high, searching from the RR pointer upward and wrapping.
    - Latch that requester's base and len, and set its grant bit.
    - If len≠0: go to ISSUE, and in the same edge drive bram_en=1, bram_ren=1, bram_addr=base.
    - If len=0: go to DRAIN with no reads issued (zero-length burst).
  - ISSUE:
    - Each cycle, increment bram_addr and decrement the remaining count.
    - Exactly len addresses are issued: base .. base+len-1, modulo 2^ADDR_WIDTH (wrap is legal, not an error).
    - After the last address: bram_ren goes to 0 and the state goes to DRAIN.
  - DRAIN:
    - Wait until the read pipeline is empty.
    - Then, in one edge: done[g]=1 for one cycle, grant goes to 0, bram_en goes to 0, the RR pointer becomes (g+1) mod N_REQ, and the state goes to IDLE.
- Data return:
  - An RD_LAT-deep shift register carries valid, last and id alongside each issued address.
  - The word for address base+i appears as rd_valid=1 with rd_data=bram_dout, exactly RD_LAT cycles after that address is driven.
  - rd_last=1 only with word len-1.
  - rd_data is held, not zeroed, when rd_valid=0.
- Latency:
  - req seen at edge k with len=L: grant at k, first rd_valid at k+RD_LAT, rd_last at k+RD_LAT+L-1, done at k+RD_LAT+L.
  - The earliest next grant is at edge k+RD_LAT+L+1 (one IDLE cycle between bursts).
  - Zero-length burst: done at k+1, with no rd_valid.
- Request rules:
  - req, req_base and req_len are sampled only in IDLE; changes during another requester's burst have no effect on it.
  - A requester dropping req mid-burst does not abort its burst.
  - req_len values larger than 2^ADDR_WIDTH are truncated to ADDR_WIDTH+1 bits internally; the caller must not request them.
- Fairness:
  - Any requester that holds req is granted within N_REQ-1 other bursts.
  - With all requesters pending after reset, the grant order is 0,1,2,3,0,...
- Invariants:
  - grant is one-hot or zero.
  - At most one done bit is high.
  - bram_ren=1 implies bram_en=1.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, ISSUE=2'b01, DRAIN=2'b10
  - default BRAM latency constant (2)
  - weight region base addresses per layer (for example 101376 for layer 1 block 12)
- One sub-module: rr_arbiter_onehot. Inputs are req and the pointer; outputs are a one-hot grant and the granted index. It is purely combinational and instantiated once.
- The FSM, counters and return pipeline stay in the top module.

Test Plan:
- Single burst: req[0]=1, base=101376, len=4, RD_LAT=2 → grant=0001 at k; bram_addr 101376..101379 at k..k+3; rd_valid k+2..k+5 with rd_id=0; rd_last at k+5; done[0] at k+6.
- All four requesting, len=3 each → grants in order 0,1,2,3; 12 rd_valid words total; each burst separated by exactly one IDLE cycle; grant never overlaps.
- len=0 on req[2] alone → done[2] pulses at k+1; bram_ren never asserted; rd_valid stays 0.
- Address wrap: base=2^18-2, len=4 → bram_addr sequence 262142, 262143, 0, 1; all 4 words returned with rd_last on the fourth.
- Reset mid-burst: rst_n=0 two cycles after grant with len=8 → next edge has all outputs 0 and state IDLE; no done; after release, a pending req[1] is granted first (pointer=0, req[0] low).
- Fairness: req[0] re-asserted immediately after its done while req[3] is pending → req[3] is granted before req[0].
